// File: rtl/boa_mem_arbiter.sv
// N-port arbiter sharing one Boa memory bus among several masters, with per-port lock,
// bounded burst quota, starvation escalation and registered response routing.

`ifndef BOA_ARBITER_RR
`define BOA_ARBITER_RR 0
`endif
`ifndef BOA_ARBITER_STATIC
`define BOA_ARBITER_STATIC 1
`endif

module boa_mem_arbiter #(
    parameter int unsigned alen      = 32,
    parameter int unsigned dlen      = 32,
    parameter int unsigned cpus      = 4,
    parameter int unsigned arbiter   = `BOA_ARBITER_RR,
    parameter int unsigned burst_max = 4,
    parameter int unsigned max_wait  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [cpus-1:0]          cpu_re,
    input  logic [cpus*dlen/8-1:0]   cpu_we,
    input  logic [cpus*alen-1:0]     cpu_addr,
    input  logic [cpus*dlen-1:0]     cpu_wdata,
    output logic [cpus*dlen-1:0]     cpu_rdata,
    output logic [cpus-1:0]          cpu_ready,
    output logic                     mem_re,
    output logic [dlen/8-1:0]        mem_we,
    output logic [alen-1:0]          mem_addr,
    output logic [dlen-1:0]          mem_wdata,
    input  logic [dlen-1:0]          mem_rdata,
    input  logic                     mem_ready,
    input  logic [cpus-1:0]          lock,
    output logic [cpus-1:0]          grant,
    output logic [cpus-1:0]          urgent
);

    localparam int unsigned bw = dlen / 8;
    localparam int unsigned rw = $clog2(burst_max + 1);
    localparam int unsigned ww = (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    localparam int unsigned iw = $clog2(cpus);
    localparam logic [rw-1:0] run_max  = rw'(burst_max);
    localparam logic [ww-1:0] wait_max = ww'(max_wait);

    logic [cpus-1:0] req;
    logic [cpus-1:0] sel;
    logic [cpus-1:0] cur;
    logic [cpus-1:0] r_req;
    logic [cpus-1:0] urg_req;
    logic            pend;
    logic            hold;
    logic [rw-1:0]   run;
    logic [ww-1:0]   wait_cnt [cpus];
    logic [iw-1:0]   cur_idx;
    logic [iw-1:0]   rr_idx;
    logic [iw:0]     rr_start;
    logic            rr_found;

    always_comb begin
        req = '0;
        for (int i = 0; i < cpus; i++) begin
            req[i] = cpu_re[i] | (|cpu_we[i*bw +: bw]);
        end
    end

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < cpus; i++) begin
            if (cur[i]) cur_idx = iw'(i);
        end
    end

    // With no previous owner the round-robin scan starts at port 0.
    assign rr_start = (|cur) ? ({1'b0, cur_idx} + (iw + 1)'(1)) : '0;
    assign hold     = pend & ~mem_ready;
    assign urg_req  = urgent & req;

    always_comb begin
        sel      = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        if (rst) begin
            sel = '0;
        end else if (hold) begin
            sel = cur;
        end else if (|(cur & req & lock)) begin
            sel = cur;
        end else if (|urg_req) begin
            sel = urg_req & (~urg_req + cpus'(1));
        end else if ((|(cur & req)) && (run < run_max)) begin
            sel = cur;
        end else if (arbiter == `BOA_ARBITER_STATIC) begin
            sel = req & (~req + cpus'(1));
        end else begin
            // Scan ends on cur itself, so it wins only as the sole requester.
            for (int k = 0; k < cpus; k++) begin
                rr_idx = iw'((32'(rr_start) + 32'(k)) % cpus);
                if (!rr_found && req[rr_idx]) begin
                    sel[rr_idx] = 1'b1;
                    rr_found    = 1'b1;
                end
            end
        end
    end

    assign grant = sel;

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < cpus; i++) begin
            if (sel[i]) begin
                mem_re    = cpu_re[i];
                mem_we    = cpu_we[i*bw +: bw];
                mem_addr  = cpu_addr[i*alen +: alen];
                mem_wdata = cpu_wdata[i*dlen +: dlen];
            end
        end
    end

    always_comb begin
        urgent    = '0;
        cpu_ready = '1;
        for (int i = 0; i < cpus; i++) begin
            urgent[i] = !rst && (max_wait != 0) && (wait_cnt[i] == wait_max);
            if (!rst) begin
                cpu_ready[i] = (pend && cur[i]) ? mem_ready : !r_req[i];
            end
        end
    end

    assign cpu_rdata = {cpus{mem_rdata}};

    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= '0;
            pend  <= 1'b0;
            r_req <= '0;
            run   <= '0;
            for (int i = 0; i < cpus; i++) wait_cnt[i] <= '0;
        end else begin
            if (|sel) cur <= sel;
            pend  <= |sel;
            r_req <= req;
            if (!hold) begin
                if (sel != cur) begin
                    run <= rw'(1);
                end else if (run != run_max) begin
                    run <= run + rw'(1);
                end
            end
            for (int i = 0; i < cpus; i++) begin
                if (sel[i] || !req[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != wait_max) begin
                    wait_cnt[i] <= wait_cnt[i] + ww'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed bench for boa_mem_arbiter: three instances (RR/quota 1, STATIC/max_wait 3,
// RR/quota 4 without escalation) share one stimulus stream.

`ifndef BOA_ARBITER_RR
`define BOA_ARBITER_RR 0
`endif
`ifndef BOA_ARBITER_STATIC
`define BOA_ARBITER_STATIC 1
`endif

module tb_boa_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   cpu_re;
    logic [15:0]  cpu_we;
    logic [127:0] cpu_addr;
    logic [127:0] cpu_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
    logic [3:0]   lock;

    logic [127:0] a_cpu_rdata, b_cpu_rdata, c_cpu_rdata;
    logic [3:0]   a_cpu_ready, b_cpu_ready, c_cpu_ready;
    logic         a_mem_re, b_mem_re, c_mem_re;
    logic [3:0]   a_mem_we, b_mem_we, c_mem_we;
    logic [31:0]  a_mem_addr, b_mem_addr, c_mem_addr;
    logic [31:0]  a_mem_wdata, b_mem_wdata, c_mem_wdata;
    logic [3:0]   a_grant, b_grant, c_grant;
    logic [3:0]   a_urgent, b_urgent, c_urgent;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    boa_mem_arbiter #(.alen(32), .dlen(32), .cpus(4), .arbiter(`BOA_ARBITER_RR),
                      .burst_max(1), .max_wait(15)) u_a (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
        .mem_re(a_mem_re), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .lock(lock), .grant(a_grant),
        .urgent(a_urgent)
    );

    boa_mem_arbiter #(.alen(32), .dlen(32), .cpus(4), .arbiter(`BOA_ARBITER_STATIC),
                      .burst_max(4), .max_wait(3)) u_b (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .lock(lock), .grant(b_grant),
        .urgent(b_urgent)
    );

    boa_mem_arbiter #(.alen(32), .dlen(32), .cpus(4), .arbiter(`BOA_ARBITER_RR),
                      .burst_max(4), .max_wait(0)) u_c (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(c_cpu_rdata), .cpu_ready(c_cpu_ready),
        .mem_re(c_mem_re), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .lock(lock), .grant(c_grant),
        .urgent(c_urgent)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_re    = '0;
        cpu_we    = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        lock      = '0;
        mem_ready = 1'b1;
        mem_rdata = '0;
    endtask

    task automatic rd(input int p, input logic [31:0] addr);
        cpu_re[p]            = 1'b1;
        cpu_addr[p*32 +: 32] = addr;
    endtask

    task automatic drop(input int p);
        cpu_re[p]            = 1'b0;
        cpu_addr[p*32 +: 32] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rr [6];
        logic [3:0] exp_urg [5];
        logic [3:0] prev;
        exp_rr  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        exp_urg = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};

        // Reset state with a request pending: nothing forwarded, everyone ready.
        idle_inputs();
        rd(2, 32'h100);
        cyc();
        check("rst_grant", a_grant, 4'b0000);
        check("rst_mem_re", a_mem_re, 1'b0);
        check("rst_ready", a_cpu_ready, 4'b1111);
        check("rst_urgent", b_urgent, 4'b0000);

        // Single requester, zero wait states.
        cyc();
        rst       = 1'b0;
        mem_rdata = 32'hcafe_0001;
        #1;
        check("single_grant0", a_grant, 4'b0100);
        check("single_mem_re", a_mem_re, 1'b1);
        check("single_addr", a_mem_addr, 32'h100);
        check("single_ready0", a_cpu_ready, 4'b1111);
        cyc();
        check("single_grant1", a_grant, 4'b0100);
        check("single_ready1", a_cpu_ready, 4'b1111);
        check("single_rdata2", a_cpu_rdata[95:64], 32'hcafe_0001);
        check("single_rdata0", a_cpu_rdata[31:0], 32'hcafe_0001);
        cyc();
        check("single_grant2", a_grant, 4'b0100);
        cyc();
        drop(2);
        #1;
        check("idle_grant", a_grant, 4'b0000);
        check("idle_mem_re", a_mem_re, 1'b0);
        check("idle_addr", a_mem_addr, 32'h0);
        check("idle_ready", a_cpu_ready, 4'b1111);

        // Round robin among ports 0, 1, 3 with a quota of one.
        do_reset();
        rd(0, 32'h10);
        rd(1, 32'h20);
        rd(3, 32'h30);
        #1;
        prev = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            check("rr_grant", a_grant, exp_rr[k]);
            check("rr_ready", a_cpu_ready, (k == 0) ? 4'b1111 : (4'b0100 | prev));
            prev = exp_rr[k];
            cyc();
        end

        // Wait states on port 1 while port 0 queues.
        do_reset();
        rd(1, 32'h200);
        #1;
        check("ws_grant0", a_grant, 4'b0010);
        cyc();
        rd(0, 32'h300);
        mem_ready = 1'b0;
        #1;
        check("ws_grant1", a_grant, 4'b0010);
        check("ws_addr1", a_mem_addr, 32'h200);
        check("ws_ready1", a_cpu_ready, 4'b1101);
        cyc();
        check("ws_grant2", a_grant, 4'b0010);
        check("ws_ready2", a_cpu_ready, 4'b1100);
        cyc();
        mem_ready = 1'b1;
        drop(1);
        #1;
        check("ws_grant3", a_grant, 4'b0001);
        check("ws_addr3", a_mem_addr, 32'h300);
        check("ws_ready3", a_cpu_ready, 4'b1110);
        cyc();
        drop(0);
        #1;
        check("ws_ready4", a_cpu_ready, 4'b1111);

        // Lock outranks urgency (STATIC, max_wait 3).
        do_reset();
        lock = 4'b1000;
        rd(3, 32'h400);
        #1;
        check("lock_grant0", b_grant, 4'b1000);
        cyc();
        rd(0, 32'h500);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("lock_grant", b_grant, 4'b1000);
            check("lock_urgent", b_urgent, exp_urg[k]);
            cyc();
        end
        lock = 4'b0000;
        #1;
        check("unlock_grant", b_grant, 4'b0001);
        check("unlock_urgent_held", b_urgent, 4'b0001);
        cyc();
        check("unlock_urgent_clr", b_urgent, 4'b0000);
        check("unlock_grant_keep", b_grant, 4'b0001);

        // Burst quota of four between ports 0 and 2.
        do_reset();
        rd(0, 32'h600);
        rd(2, 32'h700);
        #1;
        for (int k = 0; k < 12; k++) begin
            check("quota_grant", c_grant, (((k / 4) % 2) == 0) ? 4'b0001 : 4'b0100);
            cyc();
        end
        check("quota_urgent", c_urgent, 4'b0000);

        // Reset during a stalled access.
        do_reset();
        rd(1, 32'h800);
        #1;
        check("rs_grant0", a_grant, 4'b0010);
        cyc();
        mem_ready = 1'b0;
        #1;
        check("rs_hold", a_grant, 4'b0010);
        rst = 1'b1;
        #1;
        check("rs_mem_re", a_mem_re, 1'b0);
        check("rs_grant_rst", a_grant, 4'b0000);
        check("rs_ready_rst", a_cpu_ready, 4'b1111);
        check("rs_urgent_rst", a_urgent, 4'b0000);
        cyc();
        rst = 1'b0;
        #1;
        check("rs_grant_after", a_grant, 4'b0010);
        check("rs_ready_after", a_cpu_ready, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
